rw_bram_arbiter: RTL

RW_BRAM_ARBITER -- requirements
Module: rw_bram_arbiter

---
 rtl/rw_bram_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/rw_bram_arbiter.sv
// rw_bram_arbiter: 3-way round-robin BRAM access arbiter with 2-cycle read tag pipeline; RW_ARB_RMW_LOCK_EN adds grant locking
module rw_bram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2:0]              i_req_valid,
  input  logic [2:0]              i_req_write,
  input  logic [2:0]              i_req_lock,
  input  logic [3*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [3*DATA_WIDTH-1:0] i_req_wdata,
  output logic [2:0]              o_req_ready,
  output logic [2:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   o_bram_addr,
  output logic                    o_bram_write,
  output logic [DATA_WIDTH-1:0]   o_bram_wdata,
  input  logic [DATA_WIDTH-1:0]   i_bram_rdata
);
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
  logic [1:0]            rr_ptr_q, rr_ptr_d, p1, p2, sel;
  logic                  accept, write_sel;
  logic [ADDR_WIDTH-1:0] addr_sel, bram_addr_q;
  logic [DATA_WIDTH-1:0] wdata_sel, bram_wdata_q;
  logic                  bram_write_q, tag1_v_q, tag2_v_q;
  logic [1:0]            tag1_id_q, tag2_id_q;
  logic [2:0]            rsp_v_q;
  assign p1 = inc3(rr_ptr_q);
  assign p2 = inc3(p1);
`ifdef RW_ARB_RMW_LOCK_EN
  logic       lock_q, lock_d;
  logic [1:0] owner_q, owner_d;
  // winner: lock owner while locked, otherwise first valid from rr_ptr onward
  always_comb begin
    sel = lock_q ? owner_q : (i_req_valid[rr_ptr_q] ? rr_ptr_q : i_req_valid[p1] ? p1 : p2);
    accept = !i_rst && (lock_q ? i_req_valid[owner_q] : |i_req_valid);
  end
  // lock follows the lock bit of each accepted access; pointer moves only on non-locking accepts
  always_comb begin
    lock_d = accept ? i_req_lock[sel] : lock_q;
    owner_d = (accept && i_req_lock[sel]) ? sel : owner_q;
    rr_ptr_d = (accept && !i_req_lock[sel]) ? inc3(sel) : rr_ptr_q;
  end
  // lock state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_q <= 1'b0;
      owner_q <= 2'd0;
    end else begin
      lock_q <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_req_lock;
  // winner: first valid requester from rr_ptr onward
  always_comb begin
    sel = i_req_valid[rr_ptr_q] ? rr_ptr_q : i_req_valid[p1] ? p1 : p2;
    accept = !i_rst && |i_req_valid;
  end
  // pointer moves past every accepted requester
  always_comb begin
    rr_ptr_d = accept ? inc3(sel) : rr_ptr_q;
  end
`endif
  // steer the winner's request fields
  always_comb begin
    write_sel = i_req_write[sel];
    addr_sel = (sel == 2'd2) ? i_req_addr[2*ADDR_WIDTH +: ADDR_WIDTH] :
               (sel == 2'd1) ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
    wdata_sel = (sel == 2'd2) ? i_req_wdata[2*DATA_WIDTH +: DATA_WIDTH] :
                (sel == 2'd1) ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH] : i_req_wdata[DATA_WIDTH-1:0];
  end
  // pointer, BRAM command registers and read tag pipeline (two tag stages + response stage)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q <= 2'd0;
      bram_write_q <= 1'b0;
      bram_addr_q <= '0;
      bram_wdata_q <= '0;
      tag1_v_q <= 1'b0;
      tag1_id_q <= 2'd0;
      tag2_v_q <= 1'b0;
      tag2_id_q <= 2'd0;
      rsp_v_q <= 3'b000;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      bram_write_q <= accept && write_sel;
      if (accept) begin
        bram_addr_q <= addr_sel;
        bram_wdata_q <= wdata_sel;
      end
      tag1_v_q <= accept && !write_sel;
      tag1_id_q <= sel;
      tag2_v_q <= tag1_v_q;
      tag2_id_q <= tag1_id_q;
      rsp_v_q <= tag2_v_q ? (3'b001 << tag2_id_q) : 3'b000;
    end
  end
  assign o_req_ready = accept ? (3'b001 << sel) : 3'b000;
  assign o_rsp_valid = rsp_v_q;
  assign o_rsp_rdata = i_bram_rdata;
  assign o_bram_addr = bram_addr_q;
  assign o_bram_write = bram_write_q;
  assign o_bram_wdata = bram_wdata_q;
endmodule
